beverage_dispenser: RTL and testbench

BEVERAGE_DISPENSER -- requirements
Module: beverage_dispenser

---
 rtl/beverage_dispenser.sv | 207 ++++++++++++++++++++
 tb/tb_beverage_dispenser.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/beverage_dispenser.sv
// Coin-operated beverage dispenser: synchronised coin/confirm inputs, credit, price check, timed ingredient sequencing.
// Optional refund path enabled by defining BEVERAGE_DISPENSER_CANCEL_EN.
module beverage_dispenser #(
  parameter int N_PRODUCTS = 8,
  parameter int N_INGR     = 5,
  parameter int CREDIT_W   = 6,
  parameter int DUR_W      = 3,
  parameter int TICK_DIV   = 50_000_000,
  parameter logic [N_PRODUCTS*CREDIT_W-1:0]     PRICE_TABLE = {N_PRODUCTS{CREDIT_W'(3)}},
  parameter logic [N_PRODUCTS*N_INGR*DUR_W-1:0] RECIPE      = {(N_PRODUCTS*N_INGR){DUR_W'(1)}},
  localparam int SEL_W = $clog2(N_PRODUCTS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_100,
  input  logic                coin_500,
  input  logic [SEL_W-1:0]    product_sel,
  input  logic                confirm,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic [N_INGR-1:0]   ingr_en,
  output logic                busy,
  output logic                finished,
  output logic                error,
  output logic                coin_reject
);

  // state    | meaning
  // IDLE     | accepting coins, confirm and cancel
  // CHECK    | compare credit against price of latched product
  // DISPENSE | walk ingredients, one timed step each
  // DONE     | drink ready; next coin/confirm/cancel is handled as in IDLE
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DISPENSE, S_DONE} state_t;

  localparam int STEP_W = (N_INGR > 1) ? $clog2(N_INGR) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_INGR - 1);
  localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(TICK_DIV - 1);

  state_t state, state_d;
  logic [CREDIT_W-1:0] credit_d, change_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [STEP_W-1:0]   step, step_d;
  logic [TICK_W-1:0]   tick_cnt, tick_d;
  logic [DUR_W-1:0]    dur_cnt, dur_d, cur_dur;
  logic                error_d, reject_d;
  logic [CREDIT_W:0]   sum;

  logic [2:0] c100_q, c500_q, conf_q;
  logic       c100_ev, c500_ev, conf_ev, cancel_ev;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] p);
    int idx;
    idx = (int'(p) < N_PRODUCTS) ? int'(p) : 0;
    return PRICE_TABLE[idx*CREDIT_W +: CREDIT_W];
  endfunction

  function automatic logic [DUR_W-1:0] dur_of(input logic [SEL_W-1:0] p, input logic [STEP_W-1:0] s);
    int idx;
    idx = ((int'(p) < N_PRODUCTS) ? int'(p) : 0) * N_INGR + ((int'(s) < N_INGR) ? int'(s) : 0);
    return RECIPE[idx*DUR_W +: DUR_W];
  endfunction

  function automatic logic [CREDIT_W:0] add_coin(input logic [CREDIT_W-1:0] c, input int v);
    return {1'b0, c} + (CREDIT_W+1)'(v);
  endfunction

  // Two sync flops plus a history flop; event is high in the cycle before the third edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c100_q <= '0;
      c500_q <= '0;
      conf_q <= '0;
    end else begin
      c100_q <= {c100_q[1:0], coin_100};
      c500_q <= {c500_q[1:0], coin_500};
      conf_q <= {conf_q[1:0], confirm};
    end
  end

  assign c100_ev = c100_q[1] & ~c100_q[2];
  assign c500_ev = c500_q[1] & ~c500_q[2];
  assign conf_ev = conf_q[1] & ~conf_q[2];

`ifdef BEVERAGE_DISPENSER_CANCEL_EN
  logic [2:0] cancel_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cancel_q <= '0;
    else       cancel_q <= {cancel_q[1:0], cancel};
  end
  assign cancel_ev = cancel_q[1] & ~cancel_q[2];
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_ev     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      change      <= '0;
      sel_q       <= '0;
      step        <= '0;
      tick_cnt    <= '0;
      dur_cnt     <= '0;
      error       <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_d;
      credit      <= credit_d;
      change      <= change_d;
      sel_q       <= sel_d;
      step        <= step_d;
      tick_cnt    <= tick_d;
      dur_cnt     <= dur_d;
      error       <= error_d;
      coin_reject <= reject_d;
    end
  end

  assign cur_dur = dur_of(sel_q, step);

  always_comb begin
    state_d  = state;
    credit_d = credit;
    change_d = change;
    sel_d    = sel_q;
    step_d   = step;
    tick_d   = tick_cnt;
    dur_d    = dur_cnt;
    error_d  = 1'b0;
    reject_d = 1'b0;
    sum      = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (c100_ev) begin
          sum = add_coin(credit_d, 1);
          if (sum[CREDIT_W]) reject_d = 1'b1;
          else begin
            credit_d = sum[CREDIT_W-1:0];
            change_d = '0;
          end
        end
        if (c500_ev) begin
          sum = add_coin(credit_d, 5);
          if (sum[CREDIT_W]) reject_d = 1'b1;
          else begin
            credit_d = sum[CREDIT_W-1:0];
            change_d = '0;
          end
        end
        if (c100_ev || c500_ev || conf_ev || cancel_ev) state_d = S_IDLE;
        // Refund wins over a simultaneous purchase request.
        if (cancel_ev) begin
          change_d = credit_d;
          credit_d = '0;
        end else if (conf_ev) begin
          sel_d   = product_sel;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        reject_d = c100_ev | c500_ev;
        if (int'(sel_q) >= N_PRODUCTS || credit < price_of(sel_q)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          change_d = credit - price_of(sel_q);
          credit_d = '0;
          step_d   = '0;
          tick_d   = TICK_LOAD;
          dur_d    = dur_of(sel_q, '0) - 1'b1;
          state_d  = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        reject_d = c100_ev | c500_ev;
        if (cur_dur == '0 || (tick_cnt == '0 && dur_cnt == '0)) begin
          if (step == LAST_STEP) state_d = S_DONE;
          else begin
            step_d = step + 1'b1;
            tick_d = TICK_LOAD;
            dur_d  = dur_of(sel_q, step + 1'b1) - 1'b1;
          end
        end else if (tick_cnt == '0) begin
          tick_d = TICK_LOAD;
          dur_d  = dur_cnt - 1'b1;
        end else begin
          tick_d = tick_cnt - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from async-reset state so a reset drops the valves immediately.
  always_comb begin
    ingr_en = '0;
    if (state == S_DISPENSE && cur_dur != '0) ingr_en = N_INGR'(1) << step;
  end

  assign busy     = (state == S_CHECK) || (state == S_DISPENSE);
  assign finished = (state == S_DONE);

endmodule

// File: tb/tb_beverage_dispenser.sv
// Self-checking bench for beverage_dispenser: directed steps plus randomized coins/purchases against a behavioural model.
// Cancel expectations follow BEVERAGE_DISPENSER_CANCEL_EN when defined.
module tb_beverage_dispenser;
  localparam int NP = 6, NI = 5, CW = 6, DW = 3, TD = 4, CMAX = 63;
  localparam logic [NP*CW-1:0] PRICES = {6'd1, 6'd12, 6'd2, 6'd7, 6'd3, 6'd3};
  localparam logic [NP*NI*DW-1:0] RCP = {
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd0, 3'd0, 3'd0, 3'd2, 3'd1,
    3'd1, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd0, 3'd3, 3'd0, 3'd2,
    3'd1, 3'd1, 3'd1, 3'd0, 3'd1,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1};

  int price_m [NP] = '{3, 3, 7, 2, 12, 1};
  int recipe_m [NP][NI] = '{'{1,1,1,1,1}, '{1,0,1,1,1}, '{2,0,3,0,1},
                            '{0,0,0,0,1}, '{1,2,0,0,0}, '{0,0,0,0,0}};

  logic clock, reset, coin_100, coin_500, confirm, cancel;
  logic [2:0] product_sel;
  logic [CW-1:0] credit, change;
  logic [NI-1:0] ingr_en;
  logic busy, finished, error, coin_reject;

  logic s_c100, s_c500, s_zero, s_sel;
  logic [2:0] s_credit, s_change;
  logic [4:0] s_ingr;
  logic s_busy, s_fin, s_err, s_rej;

  int n_cmp, n_bad;
  int m_credit, m_change, s_m_credit;
  bit m_done;

  beverage_dispenser #(.N_PRODUCTS(NP), .N_INGR(NI), .CREDIT_W(CW), .DUR_W(DW), .TICK_DIV(TD),
                       .PRICE_TABLE(PRICES), .RECIPE(RCP)) dut (
    .clock(clock), .reset(reset), .coin_100(coin_100), .coin_500(coin_500),
    .product_sel(product_sel), .confirm(confirm), .cancel(cancel),
    .credit(credit), .change(change), .ingr_en(ingr_en), .busy(busy),
    .finished(finished), .error(error), .coin_reject(coin_reject));

  beverage_dispenser #(.N_PRODUCTS(2), .CREDIT_W(3), .TICK_DIV(TD)) dut_s (
    .clock(clock), .reset(reset), .coin_100(s_c100), .coin_500(s_c500),
    .product_sel(s_sel), .confirm(s_zero), .cancel(s_zero),
    .credit(s_credit), .change(s_change), .ingr_en(s_ingr), .busy(s_busy),
    .finished(s_fin), .error(s_err), .coin_reject(s_rej));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic coin(input int v);
    bit rej;
    if (v == 1) coin_100 = 1'b1; else coin_500 = 1'b1;
    tick(); tick();
    chk("coin_credit_before_3rd_edge", 32'(credit), m_credit);
    tick();
    rej = (m_credit + v > CMAX);
    if (!rej) begin
      m_credit += v;
      m_change = 0;
    end
    m_done = 1'b0;
    chk("coin_credit", 32'(credit), m_credit);
    chk("coin_reject", 32'(coin_reject), 32'(rej));
    chk("coin_change", 32'(change), m_change);
    chk("coin_finished", 32'(finished), 0);
    coin_100 = 1'b0; coin_500 = 1'b0;
    tick();
    chk("coin_reject_one_cycle", 32'(coin_reject), 0);
    tick();
  endtask

  task automatic s_coin(input int v);
    bit rej;
    if (v == 1) s_c100 = 1'b1; else s_c500 = 1'b1;
    repeat (3) tick();
    rej = (s_m_credit + v > 7);
    if (!rej) s_m_credit += v;
    chk("small_credit", 32'(s_credit), s_m_credit);
    chk("small_coin_reject", 32'(s_rej), 32'(rej));
    s_c100 = 1'b0; s_c500 = 1'b0;
    tick();
    chk("small_reject_one_cycle", 32'(s_rej), 0);
    tick();
  endtask

  task automatic purchase(input int p, input bit inject);
    logic [NI-1:0] q[$];
    product_sel = 3'(p);
    confirm = 1'b1;
    repeat (3) tick();
    confirm = 1'b0;
    m_done = 1'b0;
    chk("check_busy", 32'(busy), 1);
    chk("check_credit", 32'(credit), m_credit);
    tick();
    if (p >= NP || m_credit < price_m[p]) begin
      chk("error_pulse", 32'(error), 1);
      chk("error_credit_kept", 32'(credit), m_credit);
      chk("error_busy", 32'(busy), 0);
      chk("error_ingr_en", 32'(ingr_en), 0);
      tick();
      chk("error_one_cycle", 32'(error), 0);
    end else begin
      m_change = m_credit - price_m[p];
      m_credit = 0;
      for (int i = 0; i < NI; i++) begin
        if (recipe_m[p][i] == 0) q.push_back('0);
        else repeat (recipe_m[p][i] * TD) q.push_back(NI'(1) << i);
      end
      chk("buy_change", 32'(change), m_change);
      chk("buy_credit", 32'(credit), 0);
      chk("buy_busy", 32'(busy), 1);
      for (int k = 0; k < q.size(); k++) begin
        if (k > 0) tick();
        chk("ingr_en", 32'(ingr_en), 32'(q[k]));
        if (inject) begin
          chk("busy_coin_reject", 32'(coin_reject), 32'(k == 3));
          if (k == 0) coin_100 = 1'b1;
          if (k == 3) coin_100 = 1'b0;
        end
      end
      tick();
      m_done = 1'b1;
      chk("done_finished", 32'(finished), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_ingr_en", 32'(ingr_en), 0);
      chk("done_change", 32'(change), m_change);
      chk("done_credit", 32'(credit), 0);
    end
    tick();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    repeat (3) tick();
`ifdef BEVERAGE_DISPENSER_CANCEL_EN
    m_change = m_credit;
    m_credit = 0;
    m_done = 1'b0;
`endif
    chk("cancel_credit", 32'(credit), m_credit);
    chk("cancel_change", 32'(change), m_change);
    chk("cancel_finished", 32'(finished), 32'(m_done));
    cancel = 1'b0;
    tick(); tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_credit = 0; m_change = 0; m_done = 1'b0; s_m_credit = 0;
    coin_100 = 0; coin_500 = 0; confirm = 0; cancel = 0; product_sel = '0;
    s_c100 = 0; s_c500 = 0; s_zero = 0; s_sel = 0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_ingr_en", 32'(ingr_en), 0);
    chk("rst_flags", 32'({busy, finished, error, coin_reject}), 0);
    chk("rst_small_credit", 32'(s_credit), 0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // narrow credit: 5 fits, second 5 overflows, then fill to 7
    s_coin(5); s_coin(5); s_coin(1); s_coin(1); s_coin(1);

    coin(5); coin(1); coin(1);
    chk("credit_seven", 32'(credit), 7);
    purchase(0, 1'b0);
    coin(1); coin(1);
    purchase(0, 1'b0);
    coin(1);
    purchase(1, 1'b0);
    purchase(7, 1'b0);
    coin(5);
    purchase(2, 1'b1);

    while (m_credit + 5 <= CMAX) coin(5);
    coin(5);
    while (m_credit < CMAX) coin(1);
    coin(1);
    purchase(4, 1'b0);

    repeat (40) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) coin(1);
      else if (r <= 5) coin(5);
      else if (r <= 8) purchase($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      else do_cancel();
    end

    // async reset while ingredient 2 of product 0 is flowing
    coin(5);
    product_sel = 3'd0;
    confirm = 1'b1;
    repeat (3) tick();
    confirm = 1'b0;
    tick();
    repeat (8) tick();
    chk("pre_reset_ingr_en", 32'(ingr_en), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ingr_en", 32'(ingr_en), 0);
    chk("async_rst_credit", 32'(credit), 0);
    chk("async_rst_change", 32'(change), 0);
    chk("async_rst_flags", 32'({busy, finished, error, coin_reject}), 0);
    @(negedge clock);
    reset = 1'b0;
    m_credit = 0; m_change = 0; m_done = 1'b0; s_m_credit = 0;
    tick();
    chk("post_rst_credit", 32'(credit), 0);

    coin(5); coin(1);
    do_cancel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
